// File: rtl/mult_sched_ctrl.sv
// Two-requester scheduler for a mode-switchable multiplier with an in-order result FIFO.
// Optional statistics counters are built when MULT_SCHED_STATS_EN is defined.
module mult_sched_ctrl #(
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MULT_SCHED_STATS_EN
  output logic [15:0] stat_ops,
  output logic [15:0] stat_switches,
`endif
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode,
  input  logic [36:0] req0_a,
  input  logic [36:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode,
  input  logic [36:0] req1_a,
  input  logic [36:0] req1_b,
  output logic [36:0] mul_in1,
  output logic [36:0] mul_in2,
  output logic        mul_mode,
  input  logic [73:0] mul_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic        res_mode,
  output logic [73:0] res_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = 8;

  typedef enum logic [1:0] {IDLE, DRAIN, SWITCH} state_t;

  state_t          state, state_nx;
  logic            last_grant, lock_vld, lock_id;
  logic            win, win_vld, win_mode, issue, pop, credit_ok;
  logic [36:0]     win_a, win_b;
  logic [LAT-1:0]  vld_p, id_p, mode_p;
  logic            cap_vld, cap_id, cap_mode;
  logic [73:0]     cap_data;
  logic [75:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt, inflight;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A mode-mismatched winner stays locked so the switch it caused is not wasted.
  always_comb begin
    if (lock_vld)                      win = lock_id;
    else if (req0_valid && req1_valid) win = ~last_grant;
    else                               win = req1_valid;
    win_vld  = win ? req1_valid : req0_valid;
    win_mode = win ? req1_mode  : req0_mode;
    win_a    = win ? req1_a     : req0_a;
    win_b    = win ? req1_b     : req0_b;
  end

  always_comb begin
    inflight = CW'(cap_vld);
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(vld_p[i]);
  end

  // A pop in this cycle frees its slot immediately; needed to sustain one op per cycle.
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid && res_ready;
  assign credit_ok = (inflight + fifo_cnt) < (CW'(FIFO_DEPTH) + CW'(pop));

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          if (win_mode == mul_mode) issue = credit_ok;
          else                      state_nx = DRAIN;
        end
      end
      DRAIN:   if (inflight == '0) state_nx = SWITCH;
      SWITCH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req0_ready = issue && !win && !reset;
  assign req1_ready = issue &&  win && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lock_vld   <= 1'b0;
      lock_id    <= 1'b0;
      mul_mode   <= 1'b0;
      mul_in1    <= '0;
      mul_in2    <= '0;
      vld_p      <= '0;
      cap_vld    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (issue) begin
        lock_vld   <= 1'b0;
        last_grant <= win;
        mul_in1    <= win_a;
        mul_in2    <= win_b;
      end else if (state == IDLE && win_vld && win_mode != mul_mode) begin
        lock_vld <= 1'b1;
        lock_id  <= win;
      end
      if (state == SWITCH) mul_mode <= ~mul_mode;
      vld_p   <= (vld_p << 1) | LAT'(issue);
      cap_vld <= vld_p[LAT-1];
      if (cap_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(cap_vld) - CW'(pop);
    end
  end

  // Issue tags travel with the op; mul_out is captured LAT edges after issue.
  always_ff @(posedge clk) begin
    id_p     <= (id_p << 1)   | LAT'(win);
    mode_p   <= (mode_p << 1) | LAT'(mul_mode);
    cap_id   <= id_p[LAT-1];
    cap_mode <= mode_p[LAT-1];
    cap_data <= mul_out;
    if (cap_vld) mem[wr_ptr] <= {cap_id, cap_mode, cap_data};
  end

  assign {res_id, res_mode, res_data} = res_valid ? mem[rd_ptr] : 76'd0;

`ifdef MULT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops      <= '0;
      stat_switches <= '0;
    end else begin
      if (issue)           stat_ops      <= sat_inc(stat_ops);
      if (state == SWITCH) stat_switches <= sat_inc(stat_switches);
    end
  end
`endif

endmodule

// File: tb/tb_mult_sched_ctrl.sv
// Directed bench for mult_sched_ctrl; the multiplier is modelled as a LAT-cycle pipe of {mul_in1, mul_in2}.
module tb_mult_sched_ctrl;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req0_mode;
  logic [36:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_mode;
  logic [36:0] req1_a, req1_b;
  logic [36:0] mul_in1, mul_in2;
  logic        mul_mode;
  logic [73:0] mul_out, d1;
  logic        res_valid, res_ready, res_id, res_mode;
  logic [73:0] res_data;
`ifdef MULT_SCHED_STATS_EN
  logic [15:0] stat_ops, stat_switches;
`endif

  int nvec = 0;
  int nerr = 0;
  logic [75:0] expq[$];

  mult_sched_ctrl #(.LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
`ifdef MULT_SCHED_STATS_EN
    .stat_ops(stat_ops), .stat_switches(stat_switches),
`endif
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_a(req1_a), .req1_b(req1_b),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_mode(mul_mode), .mul_out(mul_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_mode(res_mode), .res_data(res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LAT=2: operand register plus one internal multiplier stage.
  always @(posedge clk) d1 <= {mul_in1, mul_in2};
  assign mul_out = d1;

  function automatic logic [75:0] ent(input logic id, input logic mode,
                                      input logic [36:0] a, input logic [36:0] b);
    return {id, mode, a, b};
  endfunction

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the result head against the expected order, then advance one clock.
  task automatic cyc();
    if (res_valid) begin
      if (expq.size() == 0) chk("spurious_res_valid", 76'(res_valid), 76'd0);
      else begin
        chk("res_head", {res_id, res_mode, res_data}, expq[0]);
        if (res_ready) void'(expq.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit g;
    int c0, c1, n;
    reset = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b1; req0_mode = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_mode = 1'b0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", 76'(req0_ready), 76'd0);
    chk("rst_ready1", 76'(req1_ready), 76'd0);
    chk("rst_res_valid", 76'(res_valid), 76'd0);
    chk("rst_res", {res_id, res_mode, res_data}, 76'd0);
    chk("rst_mul_in", {2'b00, mul_in1, mul_in2}, 76'd0);
    chk("rst_mul_mode", 76'(mul_mode), 76'd0);
`ifdef MULT_SCHED_STATS_EN
    chk("rst_stats", 76'({stat_ops, stat_switches}), 76'd0);
`endif
    req0_valid = 1'b0;
    reset = 1'b0;
    cyc();

    // Single op: result visible LAT+1 cycles after its issue edge.
    req0_valid = 1'b1; req0_a = 37'h1_2345_6789; req0_b = '0;
    #1;
    chk("t1_ready0", 76'(req0_ready), 76'd1);
    chk("t1_ready1", 76'(req1_ready), 76'd0);
    expq.push_back(ent(1'b0, 1'b0, 37'h1_2345_6789, 37'h0));
    cyc();
    req0_valid = 1'b0;
    chk("t1_mul_in", {2'b00, mul_in1, mul_in2}, {2'b00, 37'h1_2345_6789, 37'h0});
    repeat (3) begin
      chk("t1_res_early", 76'(res_valid), 76'd0);
      cyc();
    end
    chk("t1_res_valid", 76'(res_valid), 76'd1);
    chk("t1_res", {res_id, res_mode, res_data}, {2'b00, 37'h1_2345_6789, 37'h0});
    cyc();
    chk("t1_res_popped", 76'(res_valid), 76'd0);

    // Both requesters valid: strict alternation, one issue per cycle.
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      g = (i % 2 == 0);
      req0_valid = 1'b1; req1_valid = 1'b1; req0_mode = 1'b0; req1_mode = 1'b0;
      req0_a = 37'(16 + c0); req0_b = 37'(i);
      req1_a = 37'(32 + c1); req1_b = 37'(i + 100);
      #1;
      chk("t2_ready0", 76'(req0_ready), 76'(!g));
      chk("t2_ready1", 76'(req1_ready), 76'(g));
      expq.push_back(g ? ent(1'b1, 1'b0, req1_a, req1_b) : ent(1'b0, 1'b0, req0_a, req0_b));
      cyc();
      chk("t2_mul_in1", 76'(mul_in1), g ? 76'(32 + c1) : 76'(16 + c0));
      if (g) c1++; else c0++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) cyc();
    chk("t2_drained", 76'(expq.size()), 76'd0);

    // Mode change with two ops in flight; requester 0 keeps asking and must be held off.
    req0_valid = 1'b1; req0_mode = 1'b0; req0_a = 37'h55; req0_b = 37'h1;
    #1;
    chk("t3_issue_a", 76'(req0_ready), 76'd1);
    expq.push_back(ent(1'b0, 1'b0, 37'h55, 37'h1));
    cyc();
    req0_a = 37'h56;
    #1;
    chk("t3_issue_b", 76'(req0_ready), 76'd1);
    expq.push_back(ent(1'b0, 1'b0, 37'h56, 37'h1));
    cyc();
    req0_a = 37'h57;
    req1_valid = 1'b1; req1_mode = 1'b1; req1_a = 37'h77; req1_b = 37'h2;
    #1;
    chk("t3_mismatch_ready", 76'({req0_ready, req1_ready}), 76'd0);
    cyc();
    repeat (4) begin
      chk("t3_drain_ready", 76'({req0_ready, req1_ready}), 76'd0);
      chk("t3_drain_mode", 76'(mul_mode), 76'd0);
      cyc();
    end
    chk("t3_mode_switched", 76'(mul_mode), 76'd1);
    chk("t3_ready1", 76'(req1_ready), 76'd1);
    chk("t3_ready0_locked", 76'(req0_ready), 76'd0);
    expq.push_back(ent(1'b1, 1'b1, 37'h77, 37'h2));
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_mul_in1", 76'(mul_in1), 76'h77);
`ifdef MULT_SCHED_STATS_EN
    chk("t3_stat_switches", 76'(stat_switches), 76'd1);
    chk("t3_stat_ops", 76'(stat_ops), 76'd12);
`endif
    repeat (6) cyc();
    chk("t3_drained", 76'(expq.size()), 76'd0);

    // Back-pressure: exactly FIFO_DEPTH issues, then one per freed slot.
    res_ready = 1'b0; req0_valid = 1'b1; req0_mode = 1'b1; n = 0;
    for (int i = 0; i < 8; i++) begin
      req0_a = 37'(200 + n); req0_b = 37'(n);
      #1;
      chk("t4_ready0", 76'(req0_ready), 76'(i < 4));
      if (i < 4) begin
        expq.push_back(ent(1'b0, 1'b1, req0_a, req0_b));
        n++;
      end
      cyc();
    end
    res_ready = 1'b1; req0_a = 37'(200 + n); req0_b = 37'(n);
    #1;
    chk("t4_pulse_ready", 76'(req0_ready), 76'd1);
    expq.push_back(ent(1'b0, 1'b1, req0_a, req0_b));
    n++;
    cyc();
    res_ready = 1'b0;
    repeat (3) begin
      req0_a = 37'(200 + n); req0_b = 37'(n);
      #1;
      chk("t4_hold_ready", 76'(req0_ready), 76'd0);
      cyc();
    end
    res_ready = 1'b1;
    #1;
    chk("t4_resume_ready", 76'(req0_ready), 76'd1);
    expq.push_back(ent(1'b0, 1'b1, req0_a, req0_b));
    cyc();
    req0_valid = 1'b0;
    repeat (8) cyc();
    chk("t4_drained", 76'(expq.size()), 76'd0);

    // Reset one cycle after an issue discards the op.
    req1_valid = 1'b1; req1_mode = 1'b1; req1_a = 37'h1ABC; req1_b = 37'h3;
    #1;
    chk("t5_ready1", 76'(req1_ready), 76'd1);
    cyc();
    req1_valid = 1'b0;
    chk("t5_mul_in1", 76'(mul_in1), 76'h1ABC);
    cyc();
    reset = 1'b1;
    #1;
    chk("t5_rst_mul_in", {2'b00, mul_in1, mul_in2}, 76'd0);
    chk("t5_rst_mul_mode", 76'(mul_mode), 76'd0);
    chk("t5_rst_res", {res_valid, res_id, res_mode, res_data}, 76'd0);
    chk("t5_rst_ready", 76'({req0_ready, req1_ready}), 76'd0);
`ifdef MULT_SCHED_STATS_EN
    chk("t5_rst_stats", 76'({stat_ops, stat_switches}), 76'd0);
`endif
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_no_res", 76'(res_valid), 76'd0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
